// File: rtl/rib_sram_slave.sv
// RIB bus responder backed by a word-organised SRAM (data RAM target).
// One transaction at a time; response after LATENCY cycles, held until i_ribs_rdy.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready; grants i_ribs_req combinationally, commits RAM access
//   ST_WAIT | latency down-counter running, response not yet valid
//   ST_RESP | o_ribs_rsp high, rdata held until the master accepts it
module rib_sram_slave #(
   parameter int DEPTH   = 1024,
   parameter int AW      = $clog2(DEPTH),
   parameter int LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_ribs_addr,
   input  logic        i_ribs_wrcs,
   input  logic [3:0]  i_ribs_mask,
   input  logic [31:0] i_ribs_wdata,
   output logic [31:0] o_ribs_rdata,
   input  logic        i_ribs_req,
   output logic        o_ribs_gnt,
   output logic        o_ribs_rsp,
   input  logic        i_ribs_rdy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [1:0]    state;
   logic [3:0]    wait_cnt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          gnt;
   logic          unused_addr;

   // Byte offset and bits above the RAM index are don't-care (aliasing).
   assign idx         = i_ribs_addr[AW+1:2];
   assign unused_addr = ^{i_ribs_addr[31:AW+2], i_ribs_addr[1:0]};

   assign gnt        = (state == ST_IDLE) && i_ribs_req && !i_rst;
   assign o_ribs_gnt = gnt;

   // RAM is never reset; a write commits on its grant edge.
   always_ff @(posedge i_clk) begin
      if (gnt && i_ribs_wrcs) begin
         for (int b = 0; b < 4; b++) begin
            if (i_ribs_mask[b]) begin
               mem[idx][8*b +: 8] <= i_ribs_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         o_ribs_rsp   <= 1'b0;
         o_ribs_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt) begin
                  o_ribs_rdata <= i_ribs_wrcs ? 32'h0 : mem[idx];
                  if (LATENCY == 1) begin
                     state      <= ST_RESP;
                     o_ribs_rsp <= 1'b1;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= LAT_M1;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd1) begin
                  state      <= ST_RESP;
                  o_ribs_rsp <= 1'b1;
                  wait_cnt   <= '0;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (i_ribs_rdy) begin
                  state        <= ST_IDLE;
                  o_ribs_rsp   <= 1'b0;
                  o_ribs_rdata <= '0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               o_ribs_rsp <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rib_sram_slave.sv
// Scoreboard bench for rib_sram_slave: instance 0 uses LATENCY=1, instance 1 LATENCY=3.
module tb_rib_sram_slave;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic [31:0] addr  [2];
   logic        wrcs  [2];
   logic [3:0]  mask  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        req   [2];
   logic        gnt   [2];
   logic        rsp   [2];
   logic        rdy   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rib_sram_slave #(.DEPTH(1024), .LATENCY(1)) dut0 (
      .i_clk(clk), .i_rst(rst[0]), .i_ribs_addr(addr[0]), .i_ribs_wrcs(wrcs[0]),
      .i_ribs_mask(mask[0]), .i_ribs_wdata(wdata[0]), .o_ribs_rdata(rdata[0]),
      .i_ribs_req(req[0]), .o_ribs_gnt(gnt[0]), .o_ribs_rsp(rsp[0]), .i_ribs_rdy(rdy[0]));

   rib_sram_slave #(.DEPTH(1024), .LATENCY(3)) dut1 (
      .i_clk(clk), .i_rst(rst[1]), .i_ribs_addr(addr[1]), .i_ribs_wrcs(wrcs[1]),
      .i_ribs_mask(mask[1]), .i_ribs_wdata(wdata[1]), .o_ribs_rdata(rdata[1]),
      .i_ribs_req(req[1]), .o_ribs_gnt(gnt[1]), .o_ribs_rsp(rsp[1]), .i_ribs_rdy(rdy[1]));

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event (cycle %0d)", name, cyc);
   endtask

   function automatic void push(input int k, input logic [31:0] v);
      if (k == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
   endfunction

   // Monitor: a response transfers at the edge following a negedge with rsp && rdy.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rsp[k] === 1'b1 && rdy[k] === 1'b1) begin
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
               total++;
               bad++;
               $display("FAIL rsp_unexpected dut%0d: got rsp with rdata %h want no rsp", k, rdata[k]);
            end else if (k == 0) begin
               check("rsp_data_dut0", rdata[0], exp_q0.pop_front());
            end else begin
               check("rsp_data_dut1", rdata[1], exp_q1.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int k, output int gc);
      gc = -1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (gnt[k] === 1'b1) begin
            gc = cyc;
            break;
         end
      end
      if (gc < 0) fail_now("gnt_timeout");
   endtask

   task automatic wait_rsp(input int k, input int gc);
      int seen;
      seen = -1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rsp[k] === 1'b1) begin
            seen = cyc;
            break;
         end
      end
      if (seen < 0) fail_now("rsp_timeout");
      else          check("rsp_latency", 32'(seen - gc), 32'(lat_of(k)));
   endtask

   task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp);
      int gc;
      addr[k] = a; wrcs[k] = w; wdata[k] = d; mask[k] = m; req[k] = 1'b1;
      wait_gnt(k, gc);
      if (gc >= 0) push(k, exp);
      step();
      req[k] = 1'b0;
      if (gc >= 0) begin
         wait_rsp(k, gc);
         step();
      end
   endtask

   initial begin
      int g0, g1;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; addr[k] = 32'h10; wrcs[k] = 1'b1; mask[k] = 4'hF;
         wdata[k] = 32'hFFFF_FFFF; req[k] = 1'b1; rdy[k] = 1'b1;
      end
      @(negedge clk);
      check("rst_gnt_dut0", 32'(gnt[0]), 0);
      check("rst_gnt_dut1", 32'(gnt[1]), 0);
      check("rst_rsp_dut0", 32'(rsp[0]), 0);
      check("rst_rdata_dut1", rdata[1], 0);
      step();
      rst[0] = 1'b0; rst[1] = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
      step();

      // LATENCY=1: full write, read back, byte masks, zero mask, aliasing
      xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);
      xact(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44);
      xact(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0);
      xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44);
      xact(0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 4'hF, 32'h0);
      xact(0, 1'b0, 32'h0000_0006, 32'h0, 4'h0, 32'hA5A5_A5A5);

      // Reset during the grant cycle must suppress the write
      xact(0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, 32'h0);
      addr[0] = 32'h40; wrcs[0] = 1'b1; wdata[0] = 32'hFFFF_FFFF; mask[0] = 4'hF;
      req[0] = 1'b1; rst[0] = 1'b1;
      @(negedge clk);
      check("rst_gnt_suppress", 32'(gnt[0]), 0);
      step();
      rst[0] = 1'b0; req[0] = 1'b0;
      step();
      xact(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D);

      // LATENCY=3: timing and minimum grant spacing with req held
      xact(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0);
      xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D);
      addr[1] = 32'h20; wrcs[1] = 1'b0; req[1] = 1'b1;
      wait_gnt(1, g0);
      push(1, 32'hCAFE_F00D);
      step();
      wait_gnt(1, g1);
      push(1, 32'hCAFE_F00D);
      check("gnt_spacing", 32'(g1 - g0), 32'd4);
      step();
      req[1] = 1'b0;
      wait_rsp(1, g1);
      step();

      // Backpressure: response held, competing req not granted
      rdy[1] = 1'b0;
      addr[1] = 32'h20; wrcs[1] = 1'b0; req[1] = 1'b1;
      wait_gnt(1, g0);
      push(1, 32'hCAFE_F00D);
      step();
      wait_rsp(1, g0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rsp_held", 32'(rsp[1]), 1);
         check("bp_rdata_held", rdata[1], 32'hCAFE_F00D);
         check("bp_no_gnt", 32'(gnt[1]), 0);
      end
      step();
      rdy[1] = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      check("bp_rsp_drop", 32'(rsp[1]), 0);
      check("bp_regrant", 32'(gnt[1]), 1);
      g1 = cyc;
      push(1, 32'hCAFE_F00D);
      step();
      req[1] = 1'b0;
      wait_rsp(1, g1);
      step();

      // Async reset one cycle after a read grant
      xact(1, 1'b1, 32'h30, 32'h1234_5678, 4'hF, 32'h0);
      addr[1] = 32'h30; wrcs[1] = 1'b0; req[1] = 1'b1;
      wait_gnt(1, g0);
      step();
      req[1] = 1'b0;
      #2;
      rst[1] = 1'b1;
      #1;
      check("arst_rsp", 32'(rsp[1]), 0);
      check("arst_rdata", rdata[1], 0);
      exp_q1.delete();
      @(posedge clk);
      #3;
      rst[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("arst_no_late_rsp", 32'(rsp[1]), 0);
      end
      step();
      xact(1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h1234_5678);
      xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D);

      repeat (3) @(negedge clk);
      check("sb_empty_dut0", 32'(exp_q0.size()), 0);
      check("sb_empty_dut1", 32'(exp_q1.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rib_sram_slave.md
Name: rib_sram_slave

Overview:
- RIB bus responder (slave) backed by a word-organised on-chip SRAM.
- It is the far end of the RIB master port that the EXU load/store unit drives.
- It accepts one request at a time, performs byte-masked writes or word reads, and returns a response after a configurable latency.
- It holds the response until the master signals ready. It sits behind the bus interconnect as the data RAM (DTCM) target.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two ≥ 4.
- AW, $clog2(DEPTH), word-index width (derived; do not override).
- LATENCY, 1, cycles from the grant cycle to the first cycle with o_ribs_rsp high; legal range 1..15.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_ribs_addr  in  32  byte address; bits [AW+1:2] index the RAM, all other bits are ignored.
- i_ribs_wrcs  in  1  1 = write, 0 = read.
- i_ribs_mask  in  4  write byte enables; bit n enables wdata[8n+7:8n]; ignored on reads.
- i_ribs_wdata  in  32  write data.
- o_ribs_rdata  out  32  read data; valid while o_ribs_rsp is high.
- i_ribs_req  in  1  master request valid.
- o_ribs_gnt  out  1  request accepted this cycle.
- o_ribs_rsp  out  1  response valid.
- i_ribs_rdy  in  1  master accepts the response.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, wait counter = 0, o_ribs_rsp = 0, o_ribs_rdata = 0.
  - o_ribs_gnt is 0 while i_rst is high.
  - RAM contents are not cleared and are undefined after power-up.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - o_ribs_gnt = i_ribs_req (combinational).
  - On a cycle with req high (the grant cycle T), the rising edge ending T does all of the following:
    - latches addr index and wrcs;
    - for a write, updates the RAM bytes selected by mask (mask = 0 leaves the word unchanged);
    - for a read, loads the rdata register with the current RAM word;
    - for a write, loads the rdata register with 0.
  - Next state is RESP if LATENCY = 1. Otherwise it is WAIT, with counter = LATENCY-1.
- WAIT:
  - gnt = 0, rsp = 0.
  - Counter decrements each cycle; when it reaches 1, next state = RESP.
  - o_ribs_rsp therefore first rises in cycle T+LATENCY.
- RESP:
  - rsp = 1, gnt = 0. o_ribs_rdata is held stable until the transfer completes.
  - If i_ribs_rdy is high, the response transfers that cycle and the next state is IDLE, with rsp and rdata cleared to 0.
  - If i_ribs_rdy is low, the block stays in RESP indefinitely.
- One outstanding transaction only:
  - req asserted in WAIT or RESP is not granted and is not captured.
  - The master must hold req and its payload until gnt.
  - Minimum spacing between grants is LATENCY+1 cycles; the next grant is at the earliest in cycle T+LATENCY+1, given rdy at first rsp.
- Read-after-write: a read granted after a write's response observes the written data.
- Addressing:
  - addr[1:0] is ignored, so misaligned addresses access the containing word.
  - Addresses beyond DEPTH words alias (wrap) via the index bits; no error response.
- Reset mid-operation:
  - Any pending response is discarded; the block returns to IDLE.
  - A write already committed at its grant edge stays in RAM.
  - Reset asserted during the grant cycle suppresses gnt, so no write occurs.
- Simultaneous events: i_ribs_rdy outside RESP is ignored.

Test Plan:
- LATENCY=1, full-mask write: write addr 0x10 = 0xDEADBEEF, mask 4'hF, rdy=1 -> gnt at T, rsp at T+1 with rdata 0. Then read addr 0x10 -> rsp rdata 0xDEADBEEF one cycle after its gnt.
- Byte mask: after the write above, write addr 0x10, wdata 0x11223344, mask 4'b0101 -> a subsequent read returns 0xDE22BE44. A write with mask 0 leaves the word unchanged.
- LATENCY=3 timing: read granted at cycle T -> rsp low in T+1 and T+2, high in T+3. A second req held continuously is granted no earlier than T+4.
- Backpressure: hold rdy=0 for 5 cycles during RESP -> rsp stays 1 and rdata stays constant; req asserted meanwhile gets gnt=0. Raising rdy -> rsp drops the next cycle and the pending req is granted in that cycle.
- Aliasing/misalignment: with DEPTH=1024, write addr 0x0000_1004 = 0xA5A5A5A5 -> a read of addr 0x0000_0006 returns 0xA5A5A5A5.
- Async reset mid-WAIT (LATENCY=3): assert i_rst between clock edges one cycle after the grant -> rsp/rdata go to 0 immediately, no rsp appears later, the next request is granted normally, and an earlier committed write remains readable.
